// File: rtl/calc_mp_pkg.sv
// Shared types for the multi-port ALU.
//   cmd_e   : request opcodes on req_cmd_in (codes outside the enum are invalid)
//   resp_e  : response codes on out_resp
//   entry_t : one queued request {cmd, op1, op2}; operands are sized for the
//             widest supported DW, and narrower instances zero-extend into them
package calc_mp_pkg;

    localparam int DW_MAX = 64;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    // cmd is kept as raw bits so invalid opcodes travel through the queue
    // and can be answered with an error.
    typedef struct packed {
        logic [3:0]        cmd;
        logic [DW_MAX-1:0] op1;
        logic [DW_MAX-1:0] op2;
    } entry_t;

endpackage

// File: rtl/calc_mp_fifo.sv
// Per-port request queue with a one-slot reservation for the operand-2 cycle.
//   c_clk, reset : clock, async active-low reset
//   enable       : global accept enable (low until the first edge after reset)
//   cmd, data    : the port's command and operand bus
//   pop          : remove the head entry (arbiter grant)
//   ready        : port can take a new command this cycle
//   head_valid   : head entry is fully written and may be granted
//   head         : head entry
module calc_mp_fifo
    import calc_mp_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          c_clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [3:0]    cmd,
    input  logic [DW-1:0] data,
    input  logic          pop,
    output logic          ready,
    output logic          head_valid,
    output entry_t        head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] used;
    logic          op2_phase;
    logic [3:0]    hold_cmd;
    logic [DW-1:0] hold_op1;
    logic          accept;
    entry_t        mem [DEPTH];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // The reserved slot is op2_phase itself: at most one request per port
    // can be waiting for its second operand, and while it waits the port is
    // not ready, so "used < DEPTH" is the full reserved+occupied test.
    assign ready      = enable && !op2_phase && (used < CW'(DEPTH));
    assign accept     = ready && (cmd != CMD_NOP);
    assign head_valid = (used != '0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            op2_phase <= 1'b0;
            hold_cmd  <= '0;
            hold_op1  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            used      <= '0;
        end else begin
            op2_phase <= accept;
            if (accept) begin
                hold_cmd <= cmd;
                hold_op1 <= data;
            end
            if (op2_phase) wr_ptr <= ptr_next(wr_ptr);
            if (pop)       rd_ptr <= ptr_next(rd_ptr);
            case ({op2_phase, pop})
                2'b10:   used <= used + CW'(1);
                2'b01:   used <= used - CW'(1);
                default: used <= used;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge c_clk) begin
        if (op2_phase) begin
            mem[wr_ptr] <= '{cmd: hold_cmd, op1: DW_MAX'(hold_op1), op2: DW_MAX'(data)};
        end
    end

endmodule

// File: rtl/calc_mp_alu.sv
// Multi-port ALU: NPORTS request ports, each with its own queue, share one
// two-stage ALU pipeline through a round-robin arbiter. A result appears on
// the requesting port three cycles after its grant, for one cycle.
//   c_clk, reset  : clock, async active-low reset
//   req_cmd_in    : per-port command (nop/add/sub/shl/shr, others invalid)
//   req_data_in   : per-port operand bus (op1 with cmd, op2 the next cycle)
//   req_ready_out : per-port accept-ready
//   out_resp      : per-port response code (0 none, 1 ok, 2 error)
//   out_data      : per-port result, zero when out_resp is 0
module calc_mp_alu
    import calc_mp_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DW     = 32,
    parameter int DEPTH  = 2
) (
    input  logic                         c_clk,
    input  logic                         reset,
    input  logic [NPORTS-1:0][3:0]       req_cmd_in,
    input  logic [NPORTS-1:0][DW-1:0]    req_data_in,
    output logic [NPORTS-1:0]            req_ready_out,
    output logic [NPORTS-1:0][1:0]       out_resp,
    output logic [NPORTS-1:0][DW-1:0]    out_data
);

    localparam int PIW = $clog2(NPORTS);
    localparam int SW  = $clog2(DW);

    logic              alive;
    logic [NPORTS-1:0] head_valid;
    logic [NPORTS-1:0] pop;
    entry_t            head [NPORTS];

    logic [PIW-1:0]    last_grant;
    logic [PIW-1:0]    grant_port;
    logic              grant_valid;

    logic              s1_valid;
    logic [PIW-1:0]    s1_port;
    entry_t            s1_entry;

    logic [DW-1:0]     op_a;
    logic [DW-1:0]     op_b;
    logic [DW:0]       sum;
    resp_e             alu_resp;
    logic [DW-1:0]     alu_data;

    logic              s2_valid;
    logic [PIW-1:0]    s2_port;
    resp_e             s2_resp;
    logic [DW-1:0]     s2_data;

    // Holds every port not-ready through reset and until the first edge after.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) alive <= 1'b0;
        else        alive <= 1'b1;
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        calc_mp_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .c_clk      (c_clk),
            .reset      (reset),
            .enable     (alive),
            .cmd        (req_cmd_in[p]),
            .data       (req_data_in[p]),
            .pop        (pop[p]),
            .ready      (req_ready_out[p]),
            .head_valid (head_valid[p]),
            .head       (head[p])
        );
    end

    // Round-robin: first non-empty queue starting after the last grant.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_port  = last_grant;
        pop         = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = (int'(last_grant) + i) % NPORTS;
            if (!grant_valid && head_valid[idx]) begin
                grant_valid = 1'b1;
                grant_port  = PIW'(idx);
            end
        end
        if (grant_valid) pop[grant_port] = 1'b1;
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PIW'(NPORTS - 1);
            s1_valid   <= 1'b0;
            s1_port    <= '0;
            s1_entry   <= '0;
        end else begin
            s1_valid <= grant_valid;
            if (grant_valid) begin
                last_grant <= grant_port;
                s1_port    <= grant_port;
                s1_entry   <= head[grant_port];
            end
        end
    end

    assign op_a = s1_entry.op1[DW-1:0];
    assign op_b = s1_entry.op2[DW-1:0];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};

    always_comb begin
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (s1_entry.cmd)
            CMD_ADD: begin
                if (!sum[DW]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum[DW-1:0];
                end
            end
            CMD_SUB: begin
                if (op_a >= op_b) begin
                    alu_resp = RESP_OK;
                    alu_data = op_a - op_b;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = op_a << op_b[SW-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = op_a >> op_b[SW-1:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_port  <= '0;
            s2_resp  <= RESP_NONE;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_port  <= s1_port;
            s2_resp  <= alu_resp;
            s2_data  <= alu_data;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            out_resp <= '0;
            out_data <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            if (s2_valid) begin
                out_resp[s2_port] <= s2_resp;
                out_data[s2_port] <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_calc_mp_alu.sv
module tb_calc_mp_alu;
    import calc_mp_pkg::*;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic                  c_clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NP-1:0][3:0]    req_cmd_in  = '0;
    logic [NP-1:0][DW-1:0] req_data_in = '0;
    logic [NP-1:0]         req_ready_out;
    logic [NP-1:0][1:0]    out_resp;
    logic [NP-1:0][DW-1:0] out_data;

    always #5 c_clk = ~c_clk;

    calc_mp_alu #(.NPORTS(NP), .DW(DW), .DEPTH(DEPTH)) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_cmd_in    (req_cmd_in),
        .req_data_in   (req_data_in),
        .req_ready_out (req_ready_out),
        .out_resp      (out_resp),
        .out_data      (out_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    logic [3:0]    drv_cmd  [NP];
    logic [DW-1:0] drv_data [NP];

    // Transaction-level reference: per-port queues of complete requests,
    // a pending op1 holder per port, and a list of responses by due edge.
    typedef struct {
        logic [3:0]    cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } m_ent_t;

    typedef struct {
        int            due;
        int            port;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    m_ent_t mq [NP][$];
    bit     pend [NP];
    m_ent_t pent [NP];
    exp_t   exp_q [$];
    int     m_last;
    bit     m_alive;
    bit     in_reset;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    function automatic void alu_ref(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [1:0] r, output logic [DW-1:0] d);
        longint unsigned s;
        r = 2'd2;
        d = '0;
        case (c)
            4'd1: begin
                s = 64'(a) + 64'(b);
                if (s <= 64'h0000_0000_FFFF_FFFF) begin r = 2'd1; d = DW'(s); end
            end
            4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % DW); end
            4'd6: begin r = 2'd1; d = a >> (b % DW); end
            default: ;
        endcase
    endfunction

    function automatic bit m_ready(input int p);
        return m_alive && !pend[p] && (mq[p].size() < DEPTH);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mq[p].delete();
            pend[p] = 1'b0;
        end
        exp_q.delete();
        m_last  = NP - 1;
        m_alive = 1'b0;
    endtask

    // Effect of the coming rising edge on the reference state.
    task automatic model_edge();
        bit            rdy [NP];
        bit            found;
        m_ent_t        e;
        logic [1:0]    r;
        logic [DW-1:0] d;
        int            p;
        if (in_reset) return;
        for (int q = 0; q < NP; q++) rdy[q] = m_ready(q);
        found = 1'b0;
        for (int i = 1; i <= NP; i++) begin
            p = (m_last + i) % NP;
            if (!found && mq[p].size() > 0) begin
                found = 1'b1;
                e = mq[p].pop_front();
                alu_ref(e.cmd, e.op1, e.op2, r, d);
                exp_q.push_back('{due: edge_cnt + 3, port: p, resp: r, data: d});
                m_last = p;
            end
        end
        for (int q = 0; q < NP; q++) begin
            if (pend[q]) begin
                pent[q].op2 = drv_data[q];
                mq[q].push_back(pent[q]);
                pend[q] = 1'b0;
            end else if (rdy[q] && drv_cmd[q] != 4'd0) begin
                pend[q]     = 1'b1;
                pent[q].cmd = drv_cmd[q];
                pent[q].op1 = drv_data[q];
            end
        end
        m_alive = 1'b1;
    endtask

    task automatic model_check();
        logic [NP-1:0][1:0]    er;
        logic [NP-1:0][DW-1:0] ed;
        logic [NP-1:0]         erdy;
        exp_t                  x;
        er = '0;
        ed = '0;
        while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
            x = exp_q.pop_front();
            if (x.due == edge_cnt) begin
                er[x.port] = x.resp;
                ed[x.port] = x.data;
            end
        end
        for (int p = 0; p < NP; p++) erdy[p] = m_ready(p);
        check("model_ready", 256'(req_ready_out), 256'(erdy));
        check("model_resp", 256'(out_resp), 256'(er));
        check("model_data", 256'(out_data), 256'(ed));
    endtask

    // Called at a falling edge: drive, advance one rising edge, check at next fall.
    task automatic cycle();
        for (int p = 0; p < NP; p++) begin
            req_cmd_in[p]  = drv_cmd[p];
            req_data_in[p] = drv_data[p];
        end
        model_edge();
        @(posedge c_clk);
        @(negedge c_clk);
        edge_cnt++;
        model_check();
    endtask

    task automatic set_idle();
        for (int p = 0; p < NP; p++) begin
            drv_cmd[p]  = 4'd0;
            drv_data[p] = $urandom;
        end
    endtask

    task automatic idle(input int n);
        set_idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic assert_reset();
        reset    = 1'b0;
        in_reset = 1'b1;
        model_reset();
        #1;
        check("rst_resp", 256'(out_resp), 256'(0));
        check("rst_data", 256'(out_data), 256'(0));
        check("rst_ready", 256'(req_ready_out), 256'(0));
    endtask

    task automatic release_reset();
        reset    = 1'b1;
        in_reset = 1'b0;
        #1;
        check("ready_before_edge", 256'(req_ready_out), 256'(0));
        idle(1);
        check("ready_after_release", 256'(req_ready_out), 256'({NP{1'b1}}));
    endtask

    typedef struct {
        int            port;
        logic [3:0]    cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0][1:0]    er;
        logic [NP-1:0][DW-1:0] ed;
        int                    cnt;
        int                    r;
        logic [3:0]            cmds [12];

        vecs[0]  = '{0, 4'd1, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0008};
        vecs[1]  = '{1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[2]  = '{2, 4'd2, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000};
        vecs[3]  = '{3, 4'd2, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0002};
        vecs[4]  = '{0, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002};
        vecs[5]  = '{1, 4'd4, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[6]  = '{2, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
        vecs[7]  = '{3, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF};
        vecs[8]  = '{0, 4'd2, 32'h0000_0007, 32'h0000_0007, 2'd1, 32'h0000_0000};
        vecs[9]  = '{1, 4'd15, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'h0000_0000};
        vecs[10] = '{2, 4'd5, 32'hFFFF_FFFF, 32'h0000_0020, 2'd1, 32'hFFFF_FFFF};

        cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd15};

        set_idle();
        in_reset = 1'b1;
        model_reset();
        @(negedge c_clk);
        assert_reset();
        idle(2);
        release_reset();

        // Single requests from the vector table; a command held during the
        // op2 cycle must be ignored.
        foreach (vecs[v]) begin
            set_idle();
            drv_cmd[vecs[v].port]  = vecs[v].cmd;
            drv_data[vecs[v].port] = vecs[v].op1;
            cycle();
            drv_cmd[vecs[v].port]  = 4'd1;
            drv_data[vecs[v].port] = vecs[v].op2;
            cycle();
            set_idle();
            cycle();
            cycle();
            cycle();
            er = '0;
            ed = '0;
            er[vecs[v].port] = vecs[v].resp;
            ed[vecs[v].port] = vecs[v].data;
            check($sformatf("vec%0d_resp", v), 256'(out_resp), 256'(er));
            check($sformatf("vec%0d_data", v), 256'(out_data), 256'(ed));
            idle(3);
        end

        // Simultaneous burst right after reset: port order 0..3, then a
        // second burst queued behind it.
        @(negedge c_clk);
        assert_reset();
        idle(1);
        release_reset();
        for (int p = 0; p < NP; p++) begin
            drv_cmd[p]  = 4'd1;
            drv_data[p] = 32'h100 * (p + 1);
        end
        cycle();
        for (int p = 0; p < NP; p++) begin
            drv_cmd[p]  = 4'd0;
            drv_data[p] = p + 1;
        end
        cycle();
        for (int p = 0; p < NP; p++) begin
            drv_cmd[p]  = 4'd2;
            drv_data[p] = 32'h50 + p;
        end
        cycle();
        for (int p = 0; p < NP; p++) begin
            drv_cmd[p]  = 4'd0;
            drv_data[p] = 32'h10;
        end
        cycle();
        set_idle();
        cycle();
        for (int i = 0; i < NP; i++) begin
            er = '0;
            ed = '0;
            er[i] = 2'd1;
            ed[i] = 32'h100 * (i + 1) + (i + 1);
            check($sformatf("burst_resp_p%0d", i), 256'(out_resp), 256'(er));
            check($sformatf("burst_data_p%0d", i), 256'(out_data), 256'(ed));
            cycle();
        end
        idle(10);

        // Port 0 drives three back-to-back commands while ports 1..3 flood.
        cnt = 0;
        for (int t = 0; t < 30; t++) begin
            set_idle();
            if (t < 12) for (int p = 1; p < NP; p++) drv_cmd[p] = 4'd1;
            if (t < 3) begin
                drv_cmd[0]  = 4'd1;
                drv_data[0] = 32'h40 + t;
            end
            cycle();
            if (t == 0 || t == 2) check($sformatf("p0_ready_t%0d", t), 256'(req_ready_out[0]), 256'(0));
            if (out_resp[0] != 2'd0) cnt++;
        end
        check("p0_resp_count", 256'(cnt), 256'(2));

        // Random traffic on all ports; queues fill, so full/pop-reserve
        // interplay is exercised.
        for (int t = 0; t < 400; t++) begin
            for (int p = 0; p < NP; p++) begin
                r = $urandom_range(0, 15);
                drv_cmd[p] = (r < 4) ? 4'd0 : cmds[$urandom_range(0, 11)];
                case ($urandom_range(0, 3))
                    0:       drv_data[p] = $urandom_range(0, 40);
                    1:       drv_data[p] = 32'hFFFF_FFFF - $urandom_range(0, 3);
                    default: drv_data[p] = $urandom;
                endcase
            end
            cycle();
        end
        idle(30);

        // Reset with four requests in flight: nothing may come out afterwards.
        for (int p = 0; p < NP; p++) begin
            drv_cmd[p]  = 4'd1;
            drv_data[p] = 32'h20 + p;
        end
        cycle();
        set_idle();
        for (int i = 0; i < 4; i++) cycle();
        check("pre_reset_resp_p0", 256'(out_resp[0]), 256'(1));
        assert_reset();
        idle(2);
        release_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (out_resp != '0) cnt++;
        end
        check("post_reset_no_resp", 256'(cnt), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
